// File: rtl/ir_prefetch_queue.sv
// Instruction register with an integrated prefetch FIFO.
// Fetched words are buffered in a DEPTH-entry circular queue; IRWrite
// moves the head word into the instruction register, and every decode
// field is a fixed bit slice of that one register, so all fields change
// together. All state advances on the falling edge of clk so that the
// rising-edge control stage sees settled IR contents.
module ir_prefetch_queue #(
  parameter int IW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_data,
  input  logic            IRWrite,
  output logic            ir_valid,
  output logic [IW-1:0]   ir,
  output logic [3:0]      opcode,
  output logic [IW-5:0]   imm_long,
  output logic [3:0]      ra,
  output logic [1:0]      fa,
  output logic [1:0]      fb,
  output logic [IW-9:0]   imm_short,
  output logic [3:0]      rb,
  output logic [3:0]      rc,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full,
  output logic            starve
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  // Queue storage and control state
  logic [IW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic          starve_q, starve_d;

  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          starve_s;

  assign empty_s  = (count_q == '0);
  assign full_s   = (count_q == CNT_DEPTH);
  // Flush blocks acceptance so a word offered during a flush is dropped.
  assign in_ready = !full_s && !flush;

  // Qualify push/pop/starve events; no bypass, so a pop only sees stored words.
  always_comb begin
    push_s   = in_valid && in_ready;
    pop_s    = IRWrite && !empty_s && !flush;
    starve_s = IRWrite && empty_s && !flush;
  end

  // Next-state computation for pointers, occupancy, IR and status flags.
  always_comb begin
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    starve_d   = 1'b0;
    if (flush) begin
      rptr_d     = '0;
      wptr_d     = '0;
      count_d    = '0;
      ir_valid_d = 1'b0;
      starve_d   = 1'b0;
    end else begin
      if (pop_s) begin
        ir_d       = mem_q[rptr_q];
        ir_valid_d = 1'b1;
        rptr_d     = rptr_q + PTR_ONE;
      end else if (starve_s) begin
        ir_valid_d = 1'b0;
      end else begin
        ir_valid_d = ir_valid_q;
      end
      starve_d = starve_s;
      if (push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue array write; contents are don't-care after reset, so no reset here.
  always_ff @(negedge clk) begin
    if (!rst && push_s) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  // Control/IR state register with synchronous reset dominating flush.
  always_ff @(negedge clk) begin
    if (rst) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      starve_q   <= 1'b0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      starve_q   <= starve_d;
    end
  end

  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign starve    = starve_q;
  assign count     = count_q;
  assign empty     = empty_s;
  assign full      = full_s;

  // Decode fields: pure slices of the registered IR.
  assign opcode    = ir_q[IW-1:IW-4];
  assign imm_long  = ir_q[IW-5:0];
  assign ra        = ir_q[IW-5:IW-8];
  assign fa        = ir_q[IW-5:IW-6];
  assign fb        = ir_q[IW-7:IW-8];
  assign imm_short = ir_q[IW-9:0];
  assign rb        = ir_q[IW-9:IW-12];
  assign rc        = ir_q[IW-13:IW-16];

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Self-checking bench for ir_prefetch_queue: a queue-based reference
// model compared every cycle, directed scenarios with literal
// expectations, randomized traffic, and a wide (IW=32, DEPTH=8) instance.
module tb_ir_prefetch_queue;

  logic        clk;
  logic        rst, flush, in_valid, IRWrite;
  logic [15:0] in_data;
  logic        in_ready, ir_valid, empty, full, starve;
  logic [15:0] ir;
  logic [3:0]  opcode, ra, rb, rc;
  logic [11:0] imm_long;
  logic [1:0]  fa, fb;
  logic [7:0]  imm_short;
  logic [2:0]  count;

  logic        rst2, flush2, in_valid2, IRWrite2;
  logic [31:0] in_data2;
  logic        in_ready2, ir_valid2, empty2, full2, starve2;
  logic [31:0] ir2;
  logic [3:0]  opcode2, ra2, rb2, rc2;
  logic [27:0] imm_long2;
  logic [1:0]  fa2, fb2;
  logic [23:0] imm_short2;
  logic [3:0]  count2;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [15:0] mq[$];
  logic [15:0] ir_m;
  logic        irv_m;
  logic        st_m;

  ir_prefetch_queue #(.IW(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .IRWrite(IRWrite),
    .ir_valid(ir_valid), .ir(ir), .opcode(opcode), .imm_long(imm_long),
    .ra(ra), .fa(fa), .fb(fb), .imm_short(imm_short), .rb(rb), .rc(rc),
    .count(count), .empty(empty), .full(full), .starve(starve)
  );

  ir_prefetch_queue #(.IW(32), .DEPTH(8)) dut2 (
    .clk(clk), .rst(rst2), .flush(flush2), .in_valid(in_valid2),
    .in_ready(in_ready2), .in_data(in_data2), .IRWrite(IRWrite2),
    .ir_valid(ir_valid2), .ir(ir2), .opcode(opcode2), .imm_long(imm_long2),
    .ra(ra2), .fa(fa2), .fb(fb2), .imm_short(imm_short2), .rb(rb2), .rc(rc2),
    .count(count2), .empty(empty2), .full(full2), .starve(starve2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of one falling edge, written from the queue's behavioural rules.
  task automatic model_step(input logic r, input logic f, input logic iv,
                            input logic [15:0] d, input logic irw);
    int sz;
    sz = mq.size();
    if (r) begin
      mq.delete();
      ir_m = 16'h0; irv_m = 1'b0; st_m = 1'b0;
    end else if (f) begin
      mq.delete();
      irv_m = 1'b0; st_m = 1'b0;
    end else begin
      if (irw) begin
        if (sz > 0) begin
          ir_m = mq.pop_front(); irv_m = 1'b1; st_m = 1'b0;
        end else begin
          irv_m = 1'b0; st_m = 1'b1;
        end
      end else begin
        st_m = 1'b0;
      end
      if (iv && sz < 4) mq.push_back(d);
    end
  endtask

  // One cycle: drive after the rising edge, DUT and model advance on the falling edge.
  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [15:0] d, input logic irw);
    @(posedge clk);
    #2;
    rst = r; flush = f; in_valid = iv; in_data = d; IRWrite = irw;
    @(negedge clk);
    model_step(r, f, iv, d, irw);
    #1;
  endtask

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(posedge clk) begin
    if (chk_en) begin
      chk("ir", ir, ir_m);
      chk("ir_valid", ir_valid, irv_m);
      chk("starve", starve, st_m);
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == 4);
      chk("in_ready", in_ready, (mq.size() < 4) && !flush);
      chk("opcode", opcode, (ir_m >> 12) & 16'hF);
      chk("imm_long", imm_long, ir_m & 16'hFFF);
      chk("ra", ra, (ir_m >> 8) & 16'hF);
      chk("fa", fa, (ir_m >> 10) & 16'h3);
      chk("fb", fb, (ir_m >> 8) & 16'h3);
      chk("imm_short", imm_short, ir_m & 16'hFF);
      chk("rb", rb, (ir_m >> 4) & 16'hF);
      chk("rc", rc, ir_m & 16'hF);
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'hDEAD; IRWrite = 1'b0;
    rst2 = 1'b1; flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = 32'h0; IRWrite2 = 1'b0;
    mq.delete(); ir_m = 16'h0; irv_m = 1'b0; st_m = 1'b0;

    // Reset held two cycles with in_valid high: nothing may be stored.
    cyc(1'b1, 1'b0, 1'b1, 16'hDEAD, 1'b0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_ir", ir, 16'h0);
    chk("rst_ir_valid", ir_valid, 1'b0);

    // Fill to full, then pop the head and check the decoded fields.
    cyc(1'b0, 1'b0, 1'b1, 16'h1A2B, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h3C4D, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h5E6F, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h7081, 1'b0);
    chk("fill_full", full, 1'b1);
    chk("fill_in_ready", in_ready, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("pop_ir", ir, 16'h1A2B);
    chk("pop_opcode", opcode, 4'h1);
    chk("pop_ra", ra, 4'hA);
    chk("pop_fa", fa, 2'd2);
    chk("pop_fb", fb, 2'd2);
    chk("pop_rb", rb, 4'h2);
    chk("pop_rc", rc, 4'hB);
    chk("pop_imm_short", imm_short, 8'h2B);
    chk("pop_imm_long", imm_long, 12'hA2B);
    chk("pop_count", count, 3'd3);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("pop2_ir", ir, 16'h3C4D);

    // Simultaneous push+pop at count=2 across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      logic [15:0] exp_ir;
      cyc(1'b0, 1'b0, 1'b1, 16'h1000 + 16'(i), 1'b1);
      exp_ir = (i == 0) ? 16'h5E6F : (i == 1) ? 16'h7081 : 16'h1000 + 16'(i - 2);
      chk("pp_count", count, 3'd2);
      chk("pp_ir", ir, exp_ir);
    end
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("drain_ir", ir, 16'h1009);
    chk("drain_empty", empty, 1'b1);

    // Starve while a word is pushed on the same edge: no bypass.
    cyc(1'b0, 1'b0, 1'b1, 16'h9000, 1'b1);
    chk("starve_pulse", starve, 1'b1);
    chk("starve_ir_valid", ir_valid, 1'b0);
    chk("starve_ir", ir, 16'h1009);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("after_starve_ir", ir, 16'h9000);
    chk("after_starve_pulse", starve, 1'b0);
    // Back-to-back starved IRWrites give back-to-back pulses.
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("starve_a", starve, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("starve_b", starve, 1'b1);

    // Flush at count=3 with concurrent push and IRWrite.
    cyc(1'b0, 1'b0, 1'b1, 16'hA001, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'hA002, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'hA003, 1'b0);
    chk("preflush_count", count, 3'd3);
    cyc(1'b0, 1'b1, 1'b1, 16'hA004, 1'b1);
    chk("flush_count", count, 3'd0);
    chk("flush_ir_valid", ir_valid, 1'b0);
    chk("flush_ir", ir, 16'h9000);
    chk("flush_starve", starve, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("flush_dropped", starve, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 2) != 0, 16'($urandom), 1'($urandom_range(0, 1)));
    end
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Wide instance: IW=32, DEPTH=8.
    @(posedge clk); #2;
    rst2 = 1'b0; in_valid2 = 1'b1; in_data2 = 32'hF1234567;
    @(negedge clk); #1;
    in_valid2 = 1'b0;
    chk("w_count", count2, 4'd1);
    chk("w_ir_valid0", ir_valid2, 1'b0);
    @(posedge clk); #2;
    IRWrite2 = 1'b1;
    @(negedge clk); #1;
    IRWrite2 = 1'b0;
    chk("w_ir", ir2, 32'hF1234567);
    chk("w_opcode", opcode2, 4'hF);
    chk("w_imm_long", imm_long2, 28'h1234567);
    chk("w_ra", ra2, 4'h1);
    chk("w_rb", rb2, 4'h2);
    chk("w_rc", rc2, 4'h3);
    chk("w_imm_short", imm_short2, 24'h234567);
    chk("w_ir_valid", ir_valid2, 1'b1);
    chk("w_empty", empty2, 1'b1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ir_prefetch_queue.md
# ir_prefetch_queue

Parametrised instruction register with an integrated prefetch queue for the multicycle datapath. Fetched instruction words are buffered in a DEPTH-entry FIFO; on IRWrite the head word is loaded into the instruction register and all decode fields update atomically from that same word. Supports queue flush on control-flow change and reports starvation when IRWrite finds the queue empty. Sits between instruction memory and the control unit / register file address inputs.

## Interface
- IW, 16: instruction width; multiple of 4, >= 16.
- DEPTH, 4: queue entries; power of 2, >= 2.
- CW, $clog2(DEPTH+1): occupancy count width (derived, not overridden).

- clk  input  1  clock; all state updates on the falling edge.
- rst  input  1  synchronous, active-high reset, sampled on falling edge of clk.
- flush  input  1  discard queued words and invalidate IR.
- in_valid  input  1  memory offers in_data.
- in_ready  output  1  queue accepts a word this cycle.
- in_data  input  IW  fetched instruction word.
- IRWrite  input  1  pop head into IR.
- ir_valid  output  1  IR holds a live instruction.
- ir  output  IW  full instruction.
- opcode  output  4  ir[IW-1:IW-4].
- imm_long  output  IW-4  ir[IW-5:0].
- ra  output  4  ir[IW-5:IW-8].
- fa  output  2  ir[IW-5:IW-6].
- fb  output  2  ir[IW-7:IW-8].
- imm_short  output  IW-8  ir[IW-9:0].
- rb  output  4  ir[IW-9:IW-12].
- rc  output  4  ir[IW-13:IW-16].
- count  output  CW  queue occupancy, 0..DEPTH.
- empty, full  output  1  count==0, count==DEPTH.
- starve  output  1  one-cycle pulse: IRWrite while empty.

## Operation
- Storage: DEPTH x IW array, read pointer, write pointer (log2 DEPTH bits, natural wrap), count register.
- in_ready = !full && !flush (combinational). Push when in_valid && in_ready: in_data written at wptr, wptr++.
- Pop when IRWrite && !empty && !flush: head word loaded into ir; every field output updates on the same edge from that word; rptr++; ir_valid <= 1.
- IRWrite && empty: ir and fields hold, ir_valid <= 0, starve <= 1 for one cycle. No bypass: a word pushed on the same edge is not popped.
- No IRWrite: ir, fields, ir_valid hold.
- Push and pop on same edge: count unchanged, both pointers advance. Push never occurs when full even if a pop coincides.
- flush: rptr, wptr, count <= 0; ir_valid <= 0; ir and fields hold last value; concurrent push and pop are ignored; starve <= 0.
- rst: array contents unspecified; rptr, wptr, count, ir, all fields, ir_valid, starve <= 0. rst dominates flush.
- Fields are pure bit slices of the registered ir; no field may update independently of the others.

## Timing
- Reset values: ir=0, all fields=0, ir_valid=0, count=0, empty=1, full=0, starve=0, in_ready=1 once rst deasserted.
- Push-to-available latency: word pushed at falling edge k may be popped by IRWrite sampled at edge k+1.
- Pop latency: ir/fields valid immediately after the falling edge where IRWrite is sampled, ready for the following rising-edge control stage.
- count, empty, full are registered-derived and update on the same edge as the push/pop.
- starve asserted for exactly one cycle per starved IRWrite; consecutive starved IRWrites give consecutive pulses.
- Pointer wrap after DEPTH pushes/pops is seamless; ordering is strictly FIFO.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> all outputs 0, empty=1, in_ready=1 after release, no word stored.
- Fill/drain, IW=16: push 0x1A2B,0x3C4D,0x5E6F,0x7081 -> full=1, in_ready=0; IRWrite -> ir=0x1A2B, opcode=1, ra=0xA, fa=2, fb=2, rb=2, rc=0xB, imm_short=0x2B, imm_long=0xA2B.
- Simultaneous push+pop at count=2 for 10 cycles -> count stays 2, ir sequence matches push order across pointer wrap.
- Starve: IRWrite with empty while pushing 0x9000 -> starve=1 one cycle, ir_valid=0, ir unchanged; next IRWrite -> ir=0x9000.
- Flush at count=3 with concurrent in_valid and IRWrite -> count=0, ir_valid=0, ir unchanged, pushed word dropped.
- IW=32, DEPTH=8: push 0xF1234567 -> opcode=0xF, imm_long=0x1234567, rc=0x3, imm_short=0x234567.
